averager_controller: RTL and testbench

Sequencer and configuration front-end for the signed averager datapath. It latches averaging configuration at window boundaries, checks it, and gates the sample stream into the averager's `run_averaging` input. It captures each finished average into a valid/ready output register and counts frames for one-shot, N-frame or continuous acquisition. It sits between the ADC sample stream and register bank on one side and a single averager instance plus the readout logic on the other.

---
 rtl/averager_ctrl_pkg.sv | 26 ++
 rtl/averager_controller_result_holder.sv | 40 ++++
 rtl/averager_controller.sv | 147 ++++++++++++++
 tb/tb_averager_controller.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/averager_ctrl_pkg.sv
// Shared state encoding, settle length and default widths for the averager
// controller and the averager datapath it drives.
package averager_ctrl_pkg;

   localparam int AVERAGING_POINTS_BITS_DEFAULT = 48;
   localparam int INPUT_DATA_BITS_DEFAULT       = 16;
   localparam int FRAME_COUNT_BITS_DEFAULT      = 16;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_SETTLE = 3'd2;
   localparam logic [2:0] S_RUN    = 3'd3;
   localparam logic [2:0] S_ABORT  = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = S_IDLE,
      LOAD   = S_LOAD,
      SETTLE = S_SETTLE,
      RUN    = S_RUN,
      ABORT  = S_ABORT
   } state_t;

   // Cycles the averager's registered log2 stage needs after a new points value.
   localparam int SETTLE_CYCLES = 2;

endpackage

// File: rtl/averager_controller_result_holder.sv
// Output register for finished averages: valid/ready handshake plus a sticky
// overrun flag for results that arrive while the previous one is still held.
module result_holder #(
   parameter int OUTPUT_DATA_BITS = 64
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        load_valid,
   input  logic [OUTPUT_DATA_BITS-1:0] load_data,
   input  logic                        clear_overrun,
   input  logic                        result_ready,
   output logic [OUTPUT_DATA_BITS-1:0] result_data,
   output logic                        result_valid,
   output logic                        overrun
);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values and later assignments in the block win.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         result_data  <= '0;
         result_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if (clear_overrun)
            overrun <= 1'b0;
         if (load_valid) begin
            if (!result_valid || result_ready) begin
               result_data  <= load_data;
               result_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (result_valid && result_ready) begin
            result_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/averager_controller.sv
// Sequencer for one signed averager: latches and checks configuration, gates
// the sample stream into the averager and counts completed frames.
module averager_controller
   import averager_ctrl_pkg::*;
#(
   parameter int AVERAGING_POINTS_BITS = AVERAGING_POINTS_BITS_DEFAULT,
   parameter int INPUT_DATA_BITS       = INPUT_DATA_BITS_DEFAULT,
   parameter int OUTPUT_DATA_BITS      = INPUT_DATA_BITS + AVERAGING_POINTS_BITS,
   parameter int FRAME_COUNT_BITS      = FRAME_COUNT_BITS_DEFAULT
) (
   input  logic                             clock,
   input  logic                             reset_n,
   input  logic [AVERAGING_POINTS_BITS-1:0] cfg_averaging_points,
   input  logic                             cfg_shift,
   input  logic [FRAME_COUNT_BITS-1:0]      cfg_frame_count,
   input  logic                             start,
   input  logic                             stop,
   input  logic                             sample_valid,
   input  logic [INPUT_DATA_BITS-1:0]       sample_data,
   output logic                             avg_reset,
   output logic [AVERAGING_POINTS_BITS-1:0] avg_points,
   output logic                             avg_shift,
   output logic                             avg_run,
   output logic [INPUT_DATA_BITS-1:0]       avg_data_in,
   input  logic                             avg_data_valid,
   input  logic [OUTPUT_DATA_BITS-1:0]      avg_data_out,
   output logic [OUTPUT_DATA_BITS-1:0]      result_data,
   output logic                             result_valid,
   input  logic                             result_ready,
   output logic                             busy,
   output logic                             done,
   output logic                             overrun,
   output logic                             cfg_error,
   output logic [FRAME_COUNT_BITS-1:0]      frames_done
);

   state_t                             state;
   logic   [1:0]                       settle_cnt;
   logic   [FRAME_COUNT_BITS-1:0]      frame_target;
   logic   [FRAME_COUNT_BITS-1:0]      frames_inc;
   logic   [AVERAGING_POINTS_BITS-1:0] points_minus_one;
   logic                               cfg_bad;
   logic                               start_accept;

   // Shifted output needs a power-of-two window so the averager can divide by shifting.
   assign points_minus_one = cfg_averaging_points - AVERAGING_POINTS_BITS'(1);
   assign cfg_bad = (cfg_averaging_points == '0) ||
                    (cfg_shift && ((cfg_averaging_points & points_minus_one) != '0));

   assign start_accept = (state == IDLE) && start && !stop;
   assign frames_inc   = (frames_done == '1) ? frames_done
                                             : frames_done + FRAME_COUNT_BITS'(1);

   assign avg_run     = (state == RUN) && sample_valid;
   assign avg_data_in = sample_data;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         settle_cnt   <= '0;
         avg_points   <= '0;
         avg_shift    <= 1'b0;
         frame_target <= '0;
         frames_done  <= '0;
         avg_reset    <= 1'b1;
         busy         <= 1'b0;
         done         <= 1'b0;
         cfg_error    <= 1'b0;
      end else begin
         avg_reset <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (start_accept) begin
                  cfg_error   <= 1'b0;
                  frames_done <= '0;
                  busy        <= 1'b1;
                  state       <= LOAD;
               end
            end
            LOAD: begin
               avg_points   <= cfg_averaging_points;
               avg_shift    <= cfg_shift;
               frame_target <= cfg_frame_count;
               settle_cnt   <= '0;
               if (stop) begin
                  avg_reset <= 1'b1;
                  state     <= ABORT;
               end else if (cfg_bad) begin
                  cfg_error <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else begin
                  state <= SETTLE;
               end
            end
            SETTLE: begin
               if (stop) begin
                  avg_reset <= 1'b1;
                  state     <= ABORT;
               end else if (settle_cnt == 2'(SETTLE_CYCLES - 1)) begin
                  state <= RUN;
               end else begin
                  settle_cnt <= settle_cnt + 2'd1;
               end
            end
            RUN: begin
               if (avg_data_valid)
                  frames_done <= frames_inc;
               // A result arriving with stop is still counted; stop then wins the transition.
               if (stop) begin
                  avg_reset <= 1'b1;
                  state     <= ABORT;
               end else if (avg_data_valid && (frame_target != '0) &&
                            (frames_inc == frame_target)) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            ABORT: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   result_holder #(
      .OUTPUT_DATA_BITS(OUTPUT_DATA_BITS)
   ) u_result_holder (
      .clock        (clock),
      .reset_n      (reset_n),
      .load_valid   (avg_data_valid),
      .load_data    (avg_data_out),
      .clear_overrun(start_accept),
      .result_ready (result_ready),
      .result_data  (result_data),
      .result_valid (result_valid),
      .overrun      (overrun)
   );

endmodule

// File: tb/tb_averager_controller.sv
// Directed bench for averager_controller with a small behavioural averager
// standing in for the datapath that sits beside it.
module tb_averager_controller;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [47:0] cfg_averaging_points;
   logic        cfg_shift;
   logic [15:0] cfg_frame_count;
   logic        start, stop;
   logic        sample_valid;
   logic [15:0] sample_data;
   logic        avg_reset;
   logic [47:0] avg_points;
   logic        avg_shift;
   logic        avg_run;
   logic [15:0] avg_data_in;
   logic        avg_data_valid;
   logic [63:0] avg_data_out;
   logic [63:0] result_data;
   logic        result_valid;
   logic        result_ready;
   logic        busy, done, overrun, cfg_error;
   logic [15:0] frames_done;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   averager_controller dut (
      .clock               (clock),
      .reset_n             (reset_n),
      .cfg_averaging_points(cfg_averaging_points),
      .cfg_shift           (cfg_shift),
      .cfg_frame_count     (cfg_frame_count),
      .start               (start),
      .stop                (stop),
      .sample_valid        (sample_valid),
      .sample_data         (sample_data),
      .avg_reset           (avg_reset),
      .avg_points          (avg_points),
      .avg_shift           (avg_shift),
      .avg_run             (avg_run),
      .avg_data_in         (avg_data_in),
      .avg_data_valid      (avg_data_valid),
      .avg_data_out        (avg_data_out),
      .result_data         (result_data),
      .result_valid        (result_valid),
      .result_ready        (result_ready),
      .busy                (busy),
      .done                (done),
      .overrun             (overrun),
      .cfg_error           (cfg_error),
      .frames_done         (frames_done)
   );

   // Behavioural averager: sums avg_points samples, result one cycle after the last.
   logic signed [63:0] m_acc;
   logic signed [63:0] m_ext;
   logic signed [63:0] m_sum;
   logic        [47:0] m_cnt;

   assign m_ext = {{48{avg_data_in[15]}}, avg_data_in};
   assign m_sum = m_acc + m_ext;

   function automatic int log2_of(input logic [47:0] p);
      int n = 0;
      for (int i = 0; i < 48; i++)
         if (p[i]) n = i;
      return n;
   endfunction

   always @(posedge clock) begin
      if (avg_reset) begin
         m_acc          <= '0;
         m_cnt          <= '0;
         avg_data_valid <= 1'b0;
         avg_data_out   <= '0;
      end else begin
         avg_data_valid <= 1'b0;
         if (avg_run) begin
            if (m_cnt == avg_points - 48'd1) begin
               avg_data_out   <= avg_shift ? (m_sum >>> log2_of(avg_points)) : m_sum;
               avg_data_valid <= 1'b1;
               m_acc          <= '0;
               m_cnt          <= '0;
            end else begin
               m_acc <= m_sum;
               m_cnt <= m_cnt + 48'd1;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic start_cmd(input logic [47:0] points, input logic shift, input logic [15:0] frames);
      cfg_averaging_points = points;
      cfg_shift            = shift;
      cfg_frame_count      = frames;
      start                = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [15:0] d);
      sample_valid = 1'b1;
      sample_data  = d;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic stop_cmd();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b1;
      cfg_averaging_points = '0;
      cfg_shift = 1'b0;
      cfg_frame_count = '0;
      start = 1'b0;
      stop = 1'b0;
      sample_valid = 1'b0;
      sample_data = '0;
      result_ready = 1'b0;

      // Reset state and release behaviour
      #3 reset_n = 1'b0;
      #1;
      check("rst_avg_reset", avg_reset, 1);
      check("rst_busy", busy, 0);
      check("rst_result_valid", result_valid, 0);
      check("rst_avg_points", avg_points, 0);
      check("rst_frames_done", frames_done, 0);
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      check("release_avg_reset_held", avg_reset, 1);
      tick();
      check("release_avg_reset_drop", avg_reset, 0);

      // Basic frame: 10,20,30,40 shifted over 4 points -> 25
      start_cmd(48'd4, 1'b1, 16'd1);
      check("basic_busy_load", busy, 1);
      sample_valid = 1'b1;
      #1 check("basic_run_gated_load", avg_run, 0);
      tick();
      check("basic_run_gated_settle0", avg_run, 0);
      tick();
      check("basic_run_gated_settle1", avg_run, 0);
      sample_valid = 1'b0;
      tick();
      check("basic_points_latched", avg_points, 4);
      check("basic_shift_latched", avg_shift, 1);
      send(16'd10);
      send(16'd20);
      send(16'd30);
      send(16'd40);
      check("basic_valid_t1", result_valid, 0);
      tick();
      check("basic_valid_t2", result_valid, 1);
      check("basic_data", result_data, 64'd25);
      check("basic_done", done, 1);
      check("basic_busy_low", busy, 0);
      check("basic_frames", frames_done, 1);
      tick();
      check("basic_done_pulse", done, 0);
      result_ready = 1'b1;
      tick();
      check("basic_valid_cleared", result_valid, 0);

      // Signed continuous: -1,-2,-3 over 3 points, unshifted -> -6
      start_cmd(48'd3, 1'b0, 16'd0);
      repeat (3) tick();
      send(-16'sd1);
      send(-16'sd2);
      send(-16'sd3);
      tick();
      check("signed_valid1", result_valid, 1);
      check("signed_data1", result_data, -64'sd6);
      check("signed_frames1", frames_done, 1);
      check("signed_no_done1", done, 0);
      send(-16'sd1);
      send(-16'sd2);
      send(-16'sd3);
      tick();
      check("signed_data2", result_data, -64'sd6);
      check("signed_frames2", frames_done, 2);
      check("signed_busy", busy, 1);
      stop_cmd();
      check("signed_abort_avg_reset", avg_reset, 1);
      check("signed_abort_busy", busy, 1);
      tick();
      check("signed_idle_avg_reset", avg_reset, 0);
      check("signed_idle_busy", busy, 0);
      check("signed_no_done_abort", done, 0);

      // start and stop together in IDLE: nothing happens
      start = 1'b1;
      stop = 1'b1;
      tick();
      start = 1'b0;
      stop = 1'b0;
      check("start_stop_busy", busy, 0);

      // Config error: points=6 with shift
      start_cmd(48'd6, 1'b1, 16'd1);
      sample_valid = 1'b1;
      #1 check("cfg6_run_gated", avg_run, 0);
      tick();
      check("cfg6_error", cfg_error, 1);
      check("cfg6_busy", busy, 0);
      check("cfg6_run_idle", avg_run, 0);
      sample_valid = 1'b0;

      // Config error: points=0
      start_cmd(48'd0, 1'b0, 16'd1);
      check("cfg0_error_cleared", cfg_error, 0);
      tick();
      check("cfg0_error", cfg_error, 1);
      check("cfg0_busy", busy, 0);

      // Backpressure: points=1, two samples, ready held low
      result_ready = 1'b0;
      start_cmd(48'd1, 1'b0, 16'd0);
      check("bp_error_cleared", cfg_error, 0);
      repeat (3) tick();
      send(16'd7);
      send(16'd9);
      check("bp_first_valid", result_valid, 1);
      check("bp_first_data", result_data, 64'd7);
      check("bp_no_overrun_yet", overrun, 0);
      tick();
      check("bp_overrun", overrun, 1);
      check("bp_data_held", result_data, 64'd7);
      check("bp_frames", frames_done, 2);
      stop_cmd();
      tick();
      check("bp_overrun_sticky", overrun, 1);
      check("bp_valid_kept_on_stop", result_valid, 1);
      check("bp_data_kept_on_stop", result_data, 64'd7);
      result_ready = 1'b1;
      tick();
      check("bp_drained", result_valid, 0);

      // Abort mid-window: 2 of 8 samples then stop
      start_cmd(48'd8, 1'b1, 16'd1);
      check("abort_overrun_cleared", overrun, 0);
      repeat (3) tick();
      send(16'd100);
      send(16'd200);
      stop_cmd();
      check("abort_avg_reset", avg_reset, 1);
      repeat (4) tick();
      check("abort_no_result", result_valid, 0);
      check("abort_frames", frames_done, 0);

      // Restart: 8 samples of 5 shifted -> 5
      start_cmd(48'd8, 1'b1, 16'd1);
      repeat (3) tick();
      for (int i = 0; i < 8; i++)
         send(16'd5);
      check("restart_valid_t1", result_valid, 0);
      tick();
      check("restart_valid", result_valid, 1);
      check("restart_data", result_data, 64'd5);
      check("restart_done", done, 1);
      check("restart_frames", frames_done, 1);

      // Reset mid-window
      start_cmd(48'd4, 1'b0, 16'd0);
      repeat (3) tick();
      send(16'd3);
      send(16'd4);
      sample_valid = 1'b1;
      reset_n = 1'b0;
      #1;
      check("midrst_avg_reset", avg_reset, 1);
      check("midrst_busy", busy, 0);
      check("midrst_run", avg_run, 0);
      check("midrst_result_data", result_data, 0);
      check("midrst_frames", frames_done, 0);
      check("midrst_points", avg_points, 0);
      sample_valid = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
